// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says sequence datapath.
// Colour encoding matches what the sequence memory stores.
package simon_pkg;

    localparam int DEPTH = 30;
    localparam int PTR_W = 5;
    localparam int TMR_W = 4;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } colour_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        SHOW,
        GAP,
        DONE
    } player_state_t;

    function automatic logic [3:0] onehot(input colour_t c);
        logic [3:0] v;
        v = 4'b0000;
        unique case (c)
            RED:    v = 4'b0001;
            GREEN:  v = 4'b0010;
            BLUE:   v = 4'b0100;
            YELLOW: v = 4'b1000;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
// A load of N gives N+1 cycles before the cycle in which expired is seen.
module cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/sequence_player.sv
// Plays back the stored Simon sequence on the LEDs, one entry at a time.
// Each entry: memory fetch, data latch, lit hold, dark gap.
module sequence_player
    import simon_pkg::*;
#(
    parameter int SHOW_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [PTR_W-1:0] seq_len,
    input  logic [1:0]       rdata,
    output logic             r_en,
    output logic [PTR_W-1:0] r_ptr,
    output logic [3:0]       led,
    output logic             playing,
    output logic             done
);

    localparam logic [TMR_W-1:0] SHOW_LD = TMR_W'(SHOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [PTR_W-1:0] MAX_LEN = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IX = PTR_W'(DEPTH - 1);

    player_state_t    r_state;
    colour_t          r_colour;
    logic [PTR_W-1:0] r_len;
    logic [PTR_W-1:0] r_addr;
    logic             r_ren;
    logic             r_play;
    logic             r_done;

    logic [PTR_W-1:0] w_len_eff;
    logic             w_last;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_expired;

    assign w_len_eff  = (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
    assign w_last     = (r_addr == r_len - 1'b1) || (r_addr >= LAST_IX);
    assign w_tmr_load = (r_state == LATCH) || ((r_state == SHOW) && w_expired);
    assign w_tmr_val  = (r_state == LATCH) ? SHOW_LD : GAP_LD;

    cycle_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expired  (w_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_colour <= RED;
            r_len    <= '0;
            r_addr   <= '0;
            r_ren    <= 1'b0;
            r_play   <= 1'b0;
            r_done   <= 1'b0;
        end else if (abort && (r_state != IDLE)) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_ren   <= 1'b0;
            r_play  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ren  <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        r_len  <= w_len_eff;
                        r_addr <= '0;
                        r_play <= 1'b1;
                        if (w_len_eff != '0) begin
                            r_state <= FETCH;
                            r_ren   <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                FETCH: r_state <= LATCH;
                LATCH: begin
                    r_colour <= colour_t'(rdata);
                    r_state  <= SHOW;
                end
                SHOW: begin
                    if (w_expired) r_state <= GAP;
                end
                GAP: begin
                    if (w_expired) begin
                        if (w_last) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_addr  <= '0;
                        end else begin
                            r_state <= FETCH;
                            r_ren   <= 1'b1;
                            r_addr  <= r_addr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_play  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign r_en    = r_ren;
    assign r_ptr   = r_addr;
    assign led     = (r_state == SHOW) ? onehot(r_colour) : 4'b0000;
    assign playing = r_play;
    assign done    = r_done;

endmodule

// File: tb/tb_sequence_player.sv
// Randomised and directed playback scenarios checked by a queue scoreboard
// against a per-entry timing model of the player.
module tb_sequence_player;
    import simon_pkg::*;

    typedef struct {
        int addr;
        int cyc;
    } rd_t;

    typedef struct {
        int val;
        int st;
        int len;
    } run_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] seq_len = '0;
    logic [1:0] rdata = '0;
    logic       r_en;
    logic [4:0] r_ptr;
    logic [3:0] led;
    logic       playing;
    logic       done;

    logic [1:0] mem [30];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    rd_t  rq[$];
    run_t lq[$];
    int   dq[$];

    int cur_v = 0;
    int cur_st = 0;
    int cur_len = 0;

    sequence_player dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .abort   (abort),
        .seq_len (seq_len),
        .rdata   (rdata),
        .r_en    (r_en),
        .r_ptr   (r_ptr),
        .led     (led),
        .playing (playing),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (r_en && r_ptr < 5'd30) rdata <= mem[r_ptr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int hot(input int c);
        return 1 << c;
    endfunction

    // Expected reads, lit runs and done pulse; cycle k is k cycles after start.
    // A nonzero cut means playback stops after cycle cut.
    task automatic push_play(input int t0, input int len, input int cut);
        int l;
        int st;
        int en;
        rd_t r;
        run_t lr;
        l = (len > 30) ? 30 : len;
        for (int i = 0; i < l; i++) begin
            if (cut == 0 || 8 * i + 1 <= cut) begin
                r.addr = i;
                r.cyc = t0 + 8 * i + 1;
                rq.push_back(r);
            end
            st = 8 * i + 3;
            en = 8 * i + 6;
            if (cut != 0 && cut < en) en = cut;
            if (en >= st) begin
                lr.val = hot(int'(mem[i]));
                lr.st = t0 + st;
                lr.len = en - st + 1;
                lq.push_back(lr);
            end
        end
        if (cut == 0) dq.push_back(t0 + ((l == 0) ? 1 : 8 * l + 1));
    endtask

    always @(negedge clk) begin
        rd_t r;
        run_t lr;
        int d;
        if (r_en) begin
            chk("read_expected", int'(rq.size() > 0), 1);
            chk("r_ptr_in_range", int'(r_ptr < 5'd30), 1);
            if (rq.size() > 0) begin
                r = rq.pop_front();
                chk("read_addr", int'(r_ptr), r.addr);
                chk("read_cycle", cyc, r.cyc);
            end
        end
        if (done) begin
            chk("done_expected", int'(dq.size() > 0), 1);
            if (dq.size() > 0) begin
                d = dq.pop_front();
                chk("done_cycle", cyc, d);
            end
        end
        if (led != 4'b0000 && int'(led) == cur_v) begin
            cur_len++;
        end else begin
            if (cur_v != 0) begin
                chk("led_run_expected", int'(lq.size() > 0), 1);
                if (lq.size() > 0) begin
                    lr = lq.pop_front();
                    chk("led_value", cur_v, lr.val);
                    chk("led_start", cur_st, lr.st);
                    chk("led_len", cur_len, lr.len);
                end
            end
            cur_v = int'(led);
            cur_st = cyc;
            cur_len = 1;
        end
    end

    // mode 0: plain or aborted at cycle cut; 1: restart/seq_len poke; 2: reset at cut
    task automatic run(input int len, input int cut, input int mode);
        int t0;
        int l;
        int ended;
        l = (len > 30) ? 30 : len;
        ended = 0;
        @(negedge clk);
        seq_len = 5'(len);
        start = 1'b1;
        t0 = cyc;
        push_play(t0, len, cut);
        for (int k = 1; k <= 8 * l + 12; k++) begin
            @(negedge clk);
            start = (mode == 1 && k == 5);
            if (mode == 1 && k == 5) seq_len = 5'd5;
            abort = (mode == 0 && cut != 0 && k == cut);
            if (mode == 0 && cut != 0 && k == cut + 1) begin
                chk("abort_led", int'(led), 0);
                chk("abort_r_ptr", int'(r_ptr), 0);
                chk("abort_playing", int'(playing), 0);
            end
            if (mode == 2 && k == cut) begin
                #2 reset_n = 1'b0;
                #1;
                chk("rst_r_en", int'(r_en), 0);
                chk("rst_r_ptr", int'(r_ptr), 0);
                chk("rst_led", int'(led), 0);
                chk("rst_playing", int'(playing), 0);
                chk("rst_done", int'(done), 0);
                @(negedge clk);
                reset_n = 1'b1;
            end
            if (!playing && k > 1) begin
                ended = 1;
                break;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        chk("playback_ended", ended, 1);
        if (mode != 2 && cut == 0) begin
            chk("idle_cycle", cyc - t0, (l == 0) ? 2 : 8 * l + 2);
        end
        repeat (3) @(negedge clk);
        chk("reads_left", rq.size(), 0);
        chk("runs_left", lq.size(), 0);
        chk("dones_left", dq.size(), 0);
    endtask

    initial begin
        int len;
        int l;
        int cut;
        for (int i = 0; i < 30; i++) mem[i] = 2'($urandom_range(0, 3));
        repeat (3) @(negedge clk);
        chk("reset_r_en", int'(r_en), 0);
        chk("reset_r_ptr", int'(r_ptr), 0);
        chk("reset_led", int'(led), 0);
        chk("reset_playing", int'(playing), 0);
        chk("reset_done", int'(done), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        mem[0] = 2'd1;
        mem[1] = 2'd0;
        mem[2] = 2'd3;
        run(3, 0, 0);
        run(0, 0, 0);
        run(31, 0, 0);
        run(3, 12, 0);
        run(3, 0, 0);
        run(3, 0, 1);
        run(3, 7, 2);

        @(negedge clk);
        seq_len = 5'd3;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_idle", int'(playing), 0);
        repeat (3) @(negedge clk);
        chk("abort_start_quiet", int'(playing), 0);

        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 30; i++) mem[i] = 2'($urandom_range(0, 3));
            len = $urandom_range(0, 31);
            l = (len > 30) ? 30 : len;
            cut = 0;
            if (l > 0 && $urandom_range(0, 2) == 0) cut = $urandom_range(1, 8 * l);
            run(len, cut, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
